mest_pro_segment_decoder: RTL and testbench
===========================================

# mest_pro_segment_decoder

Converts 7-segment drive patterns back into 4-bit hex values; the inverse of the output stage's segment encoding. Samples a segment bus on a strobe, requires a pattern to be stable for a programmable number of samples, then decodes it and presents the result on a valid/ready handshake. Used as a display-readback checker and as the front end for capturing segment data from external display-driven sources.

## Interface
- `MEM_WIDTH`, 7: segment bus width. Bit 6 = a … bit 0 = g. Only 7 is supported.
- `STABLE_CYCLES`, 4: consecutive identical samples needed to accept a pattern. Range 1–255.
- `clk` input 1: clock. All logic on the rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_sample` input 1: sample strobe. `i_segments` is captured only in cycles where `i_sample` = 1.
- `i_segments` input MEM_WIDTH: segment pattern, active-high per segment.
- `i_ready` input 1: consumer accepts the current result.
- `o_valid` output 1: a decoded result is pending.
- `o_value` output 4: decoded hex digit.
- `o_blank` output 1: accepted pattern was all-off (`0000000`). `o_value` = 0.
- `o_error` output 1: accepted pattern is not in the decode table. `o_value` = 0.
- `o_ambiguous` output 1: accepted pattern was `0011111`.
- `o_overrun` output 1: sticky. A new result replaced an unconsumed one.

## Operation
- Decode table (pattern -> value):
  - `1111110`->0, `0110000`->1, `1101101`->2, `1111001`->3, `0110011`->4, `1011011`->5, `1011111`->6, `1110000`->7
  - `1111111`->8, `1110011`->9, `1110111`->A, `0011111`->B with `o_ambiguous`=1, `0001101`->C, `0111101`->D, `1001111`->E, `1000111`->F
  - `0000000`->blank. Every other pattern ->error.
- State machine: IDLE, TRACK, LOCKED.
  - IDLE: no sample since reset. The first strobe loads the candidate register, sets count = 1, and moves to TRACK.
  - TRACK: on a strobe with the same pattern, count increments. On a strobe with a different pattern, the candidate reloads and count = 1.
  - Acceptance: when count reaches STABLE_CYCLES, the pattern is accepted and the state moves to LOCKED. With STABLE_CYCLES = 1, the first strobe of a pattern accepts it immediately.
  - LOCKED: strobes with the accepted pattern are ignored, so there is no re-emission. A strobe with a different pattern loads the candidate, sets count = 1 and moves to TRACK. If STABLE_CYCLES = 1, it accepts immediately instead.
  - Returning to a previously accepted pattern after a different one produces a new result.
- Count saturates at STABLE_CYCLES. Its width is ceil(log2(STABLE_CYCLES+1)).
- Output handshake:
  - Acceptance loads `o_value` and the `o_blank`/`o_error`/`o_ambiguous` flags together and sets `o_valid`.
  - A transfer happens in any cycle where `o_valid` and `i_ready` are both 1. `o_valid` clears the next cycle unless a new acceptance occurs in the same cycle.
  - Acceptance while `o_valid`=1 and `i_ready`=0: the new result overwrites the old one, `o_valid` stays 1, and `o_overrun` sets.
  - Acceptance in the same cycle as a transfer: the old result is transferred, the new one loads, `o_valid` stays 1, and there is no overrun.
- `o_overrun` clears only on reset.
- Cycles with `i_sample` = 0 change nothing in the tracker. The handshake still operates.

## Timing
- Reset: state = IDLE, count = 0, candidate = 0. All outputs are 0.
- Reset asserted mid-tracking or while a result is pending discards everything. There is no output during reset.
- Latency: the strobe cycle that completes acceptance is edge N. `o_valid` and the result appear after edge N, i.e. in cycle N+1.
- Outputs are registered. There is no combinational path from inputs to outputs.
- `i_ready` may be held high continuously. Each result then shows `o_valid` for exactly one cycle.
- Result fields are stable while `o_valid`=1 unless overwritten by an overrun.

## Test plan
- Reset, then `0110000` strobed 4 consecutive cycles with `i_ready`=1: one-cycle `o_valid` the cycle after the 4th strobe, `o_value`=1, all flags 0. Further identical strobes produce nothing.
- Pattern `1111001` for 3 strobes, then `1101101` for 4 strobes, STABLE_CYCLES=4: a single result with `o_value`=2. No result for 3.
- Sweep all 16 table entries plus blank and `1010101`, each held 4 strobes with gaps where `i_sample`=0:
  - correct values for every table entry;
  - `0011111` gives B with `o_ambiguous`=1;
  - blank gives `o_blank`=1;
  - `1010101` gives `o_error`=1 with `o_value`=0.
- `i_ready`=0, accept `1111110`, then accept `1110000`:
  - `o_valid` stays 1, `o_value`=7, `o_overrun`=1;
  - raising `i_ready` clears `o_valid` next cycle;
  - `o_overrun` stays 1 until `i_rst`.
- Assert `i_rst` after 3 of 4 stable strobes, release, then give one more strobe: no result. Four fresh strobes are needed.
- STABLE_CYCLES=1, alternating `1111111`/`0000000` every strobe with `i_ready`=1: a result every strobe, with values 8, blank, 8, …, and no overrun.

Source files
------------

// File: rtl/mest_pro_segment_decoder.sv
// mest_pro_segment_decoder: debounces a strobed 7-segment bus and decodes the stable pattern to a hex digit behind valid/ready.
module mest_pro_segment_decoder #(
  parameter int MEM_WIDTH     = 7,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_sample,
  input  logic [MEM_WIDTH-1:0] i_segments,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [3:0]           o_value,
  output logic                 o_blank,
  output logic                 o_error,
  output logic                 o_ambiguous,
  output logic                 o_overrun
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STABLE_CYCLES);
  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;
  state_t state_q, state_d;
  logic [MEM_WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic same, load, accept;
  logic valid_q, blank_q, error_q, amb_q, ovr_q;
  logic [3:0] value_q;
  logic [3:0] dec_val;
  logic dec_blank, dec_err, dec_amb;
  always_comb begin
    dec_val   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    dec_amb   = 1'b0;
    case (i_segments)
      7'b1111110: dec_val = 4'h0;
      7'b0110000: dec_val = 4'h1;
      7'b1101101: dec_val = 4'h2;
      7'b1111001: dec_val = 4'h3;
      7'b0110011: dec_val = 4'h4;
      7'b1011011: dec_val = 4'h5;
      7'b1011111: dec_val = 4'h6;
      7'b1110000: dec_val = 4'h7;
      7'b1111111: dec_val = 4'h8;
      7'b1110011: dec_val = 4'h9;
      7'b1110111: dec_val = 4'hA;
      7'b0011111: begin
        dec_val = 4'hB;
        dec_amb = 1'b1;
      end
      7'b0001101: dec_val = 4'hC;
      7'b0111101: dec_val = 4'hD;
      7'b1001111: dec_val = 4'hE;
      7'b1000111: dec_val = 4'hF;
      7'b0000000: dec_blank = 1'b1;
      default:    dec_err = 1'b1;
    endcase
  end
  // A strobe repeating the locked pattern is ignored so a held digit is reported once.
  always_comb begin
    same    = (state_q != IDLE) && (i_segments == cand_q);
    load    = i_sample && !((state_q == LOCKED) && same);
    cnt_d   = !load ? cnt_q : same ? ((cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1) : CW'(1);
    accept  = load && (cnt_d == LIMIT);
    cand_d  = load ? i_segments : cand_q;
    state_d = accept ? LOCKED : load ? TRACK : state_q;
  end
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      value_q <= 4'h0;
      blank_q <= 1'b0;
      error_q <= 1'b0;
      amb_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      valid_q <= accept | (valid_q & ~i_ready);
      ovr_q   <= ovr_q | (accept & valid_q & ~i_ready);
      if (accept) begin
        value_q <= dec_val;
        blank_q <= dec_blank;
        error_q <= dec_err;
        amb_q   <= dec_amb;
      end
    end
  end
  assign o_valid     = valid_q;
  assign o_value     = value_q;
  assign o_blank     = blank_q;
  assign o_error     = error_q;
  assign o_ambiguous = amb_q;
  assign o_overrun   = ovr_q;
endmodule

// File: tb/tb_mest_pro_segment_decoder.sv
// tb_mest_pro_segment_decoder: scoreboard bench for the segment decoder at STABLE_CYCLES 4 and 1.
module tb_mest_pro_segment_decoder;
  logic clk = 1'b0, rst = 1'b1, sample = 1'b0, ready = 1'b0;
  logic [6:0] seg = '0;
  logic v, bl, er, am, ov, v1, bl1, er1, am1, ov1;
  logic [3:0] val, val1;
  int checks = 0, fails = 0;
  logic [6:0] exp_q[$], obs_q[$], exp1_q[$];
  logic [6:0] pats [18] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
                            7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                            7'b0001101, 7'b0111101, 7'b1001111, 7'b1000111, 7'b0000000, 7'b1010101};
  mest_pro_segment_decoder #(.MEM_WIDTH(7), .STABLE_CYCLES(4)) dut (
    .clk(clk), .i_rst(rst), .i_sample(sample), .i_segments(seg), .i_ready(ready),
    .o_valid(v), .o_value(val), .o_blank(bl), .o_error(er), .o_ambiguous(am), .o_overrun(ov));
  mest_pro_segment_decoder #(.MEM_WIDTH(7), .STABLE_CYCLES(1)) dut1 (
    .clk(clk), .i_rst(rst), .i_sample(sample), .i_segments(seg), .i_ready(ready),
    .o_valid(v1), .o_value(val1), .o_blank(bl1), .o_error(er1), .o_ambiguous(am1), .o_overrun(ov1));
  always #5 clk = ~clk;
  // Expected {blank, error, ambiguous, value} for entry i of pats.
  function automatic logic [6:0] expect_of(input int i);
    logic [6:0] r;
    r = {3'b000, i[3:0]};
    if (i == 11) r = r | 7'h10;
    if (i == 16) r = 7'h40;
    if (i == 17) r = 7'h20;
    return r;
  endfunction
  task automatic cycle(input logic s, input logic [6:0] p, input logic r);
    sample = s;
    seg    = p;
    ready  = r;
    #1;
    if (v && r) obs_q.push_back({bl, er, am, val});
    @(posedge clk);
    #1;
  endtask
  task automatic strobes(input logic [6:0] p, input int n, input logic r);
    repeat (n) cycle(1'b1, p, r);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    cycle(1'b0, 7'h00, 1'b0);
    cycle(1'b1, 7'b0110000, 1'b0);
    checks++;
    if ({v, val, bl, er, am, ov} !== 9'h0) begin
      fails++;
      $display("FAIL reset_outputs got %b want 0", {v, val, bl, er, am, ov});
    end
    checks++;
    if ({v1, val1, bl1, er1, am1, ov1} !== 9'h0) begin
      fails++;
      $display("FAIL reset_outputs_s1 got %b want 0", {v1, val1, bl1, er1, am1, ov1});
    end
    rst = 1'b0;
    cycle(1'b0, 7'h00, 1'b1);
  endtask
  task automatic test_basic;
    logic [6:0] o, e;
    exp_q.push_back(expect_of(1));
    strobes(7'b0110000, 3, 1'b1);
    checks++;
    if (v !== 1'b0) begin
      fails++;
      $display("FAIL basic_early_valid got %b want 0", v);
    end
    strobes(7'b0110000, 1, 1'b1);
    checks++;
    if (v !== 1'b1 || val !== 4'h1) begin
      fails++;
      $display("FAIL basic_latency got valid=%b value=%h want valid=1 value=1", v, val);
    end
    strobes(7'b0110000, 4, 1'b1);
    repeat (3) cycle(1'b0, 7'h00, 1'b1);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL basic_result got %b want %b", o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic test_switch;
    logic [6:0] o, e;
    exp_q.push_back(expect_of(2));
    strobes(7'b1111001, 3, 1'b1);
    strobes(7'b1101101, 4, 1'b1);
    repeat (2) cycle(1'b0, 7'h00, 1'b1);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL switch_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL switch_result got %b want %b", o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic test_sweep;
    logic [6:0] o, e;
    for (int i = 0; i < 18; i++) begin
      exp_q.push_back(expect_of(i));
      repeat (4) begin
        cycle(1'b1, pats[i], 1'b1);
        cycle(1'b0, pats[i], 1'b1);
      end
    end
    repeat (2) cycle(1'b0, 7'h00, 1'b1);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL sweep_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL sweep_result[%0d] got %b want %b", i, o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic test_overrun;
    logic [6:0] o, e;
    exp_q.push_back(expect_of(7));
    strobes(7'b1111110, 4, 1'b0);
    checks++;
    if (v !== 1'b1 || val !== 4'h0 || ov !== 1'b0) begin
      fails++;
      $display("FAIL overrun_first got valid=%b value=%h ovr=%b want 1 0 0", v, val, ov);
    end
    strobes(7'b1110000, 4, 1'b0);
    checks++;
    if (v !== 1'b1 || val !== 4'h7 || ov !== 1'b1) begin
      fails++;
      $display("FAIL overrun_second got valid=%b value=%h ovr=%b want 1 7 1", v, val, ov);
    end
    cycle(1'b0, 7'h00, 1'b1);
    checks++;
    if (v !== 1'b0 || ov !== 1'b1) begin
      fails++;
      $display("FAIL overrun_drain got valid=%b ovr=%b want 0 1", v, ov);
    end
    repeat (3) cycle(1'b0, 7'h00, 1'b1);
    checks++;
    if (ov !== 1'b1) begin
      fails++;
      $display("FAIL overrun_sticky got %b want 1", ov);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL overrun_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL overrun_result got %b want %b", o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic test_reset_mid;
    logic [6:0] o, e;
    strobes(7'b0110011, 3, 1'b1);
    rst = 1'b1;
    cycle(1'b0, 7'h00, 1'b1);
    rst = 1'b0;
    checks++;
    if (v !== 1'b0 || ov !== 1'b0) begin
      fails++;
      $display("FAIL midreset_clear got valid=%b ovr=%b want 0 0", v, ov);
    end
    strobes(7'b0110011, 1, 1'b1);
    repeat (2) cycle(1'b0, 7'h00, 1'b1);
    strobes(7'b0110011, 2, 1'b1);
    checks++;
    if (v !== 1'b0 || obs_q.size() !== 0) begin
      fails++;
      $display("FAIL midreset_early got valid=%b results=%0d want 0 0", v, obs_q.size());
    end
    exp_q.push_back(expect_of(4));
    strobes(7'b0110011, 1, 1'b1);
    repeat (2) cycle(1'b0, 7'h00, 1'b1);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL midreset_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL midreset_result got %b want %b", o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic test_stable_one;
    logic [6:0] p, e;
    rst = 1'b1;
    cycle(1'b0, 7'h00, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      p = (k % 2 == 1) ? 7'b0000000 : 7'b1111111;
      exp1_q.push_back((k % 2 == 1) ? 7'h40 : 7'h08);
      cycle(1'b1, p, 1'b1);
      e = exp1_q.pop_front();
      checks++;
      if (v1 !== 1'b1 || {bl1, er1, am1, val1} !== e || ov1 !== 1'b0) begin
        fails++;
        $display("FAIL stable1_result[%0d] got valid=%b res=%b ovr=%b want 1 %b 0", k, v1, {bl1, er1, am1, val1}, ov1, e);
      end
    end
    cycle(1'b0, 7'h00, 1'b1);
    checks++;
    if (v1 !== 1'b0 || ov1 !== 1'b0) begin
      fails++;
      $display("FAIL stable1_end got valid=%b ovr=%b want 0 0", v1, ov1);
    end
    obs_q.delete();
  endtask
  initial begin
    test_reset;
    test_basic;
    test_switch;
    test_sweep;
    test_overrun;
    test_reset_mid;
    test_stable_one;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
